// File: rtl/uart_tx_param.sv
// Bit-rate UART serialiser with a write FIFO; parity frame bit enabled by UART_TX_PARITY_EN.
// Latency: a word pushed into an idle block puts its start bit on the line two edges later.
// Backpressure: ready = !full; valid while !ready is dropped silently.

// Generic synchronous FIFO with the head word always presented on o_rd_dat.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: o_wr_rdy low when full; a pop while empty is ignored.
module uart_tx_param_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr_vld,
  input  logic [WIDTH-1:0]           i_wr_dat,
  output logic                       o_wr_rdy,
  input  logic                       i_rd_pop,
  output logic                       o_rd_vld,
  output logic [WIDTH-1:0]           o_rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_push   = i_wr_vld && !w_full;
  assign w_pop    = i_rd_pop && (r_count != '0);
  assign o_wr_rdy = !w_full;
  assign o_rd_vld = (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                            clk_115200hz,
  input  logic                            reset,
  input  logic [DATA_BITS-1:0]            data_in,
  input  logic                            valid,
  output logic                            ready,
  output logic                            out,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (MSB_FIRST != 0 && MSB_FIRST != 1) || (PARITY_ODD != 0 && PARITY_ODD != 1) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("uart_tx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               r_state;
  logic                 r_out;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif

  logic                 w_fifo_vld;
  logic [DATA_BITS-1:0] w_head;
  logic [CW-1:0]        w_count;
  logic                 w_last_stop;
  logic                 w_pop;
  logic                 w_tx_bit;
  logic [DATA_BITS-1:0] w_shift_nxt;

  uart_tx_param_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (clk_115200hz),
    .i_reset  (reset),
    .i_wr_vld (valid),
    .i_wr_dat (data_in),
    .o_wr_rdy (ready),
    .i_rd_pop (w_pop),
    .o_rd_vld (w_fifo_vld),
    .o_rd_dat (w_head),
    .o_count  (w_count)
  );

  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_pop       = w_fifo_vld &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_last_stop));

  // The shift register always presents the next bit at one fixed end.
  assign w_tx_bit    = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];
  assign w_shift_nxt = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

  assign out        = r_out;
  assign busy       = (r_state != IDLE) || (w_count != '0);
  assign fifo_count = w_count;

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_out      <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_out <= 1'b1;
          if (w_pop) r_state <= START;
        end
        START: begin
          r_out     <= 1'b0;
          r_bit_cnt <= '0;
          r_state   <= DATA;
        end
        DATA: begin
          r_out   <= w_tx_bit;
          r_shift <= w_shift_nxt;
          if (r_bit_cnt == LAST_BIT) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_state    <= PARITY;
`else
            r_state    <= STOP;
`endif
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          r_out   <= r_par;
          r_state <= STOP;
        end
`endif
        STOP: begin
          r_out <= 1'b1;
          if (w_last_stop) begin
            r_stop_cnt <= 1'b0;
            r_state    <= w_pop ? START : IDLE;
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: begin
          r_out   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
      // A pop only happens in IDLE or on the last stop cycle, never while DATA shifts.
      if (w_pop) begin
        r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
        r_par   <= (^w_head) ^ (PARITY_ODD != 0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: reset, LSB/MSB framing, back-to-back, backpressure, parity.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;

  // DUT 0: default parameters
  logic [7:0] d0_dat;
  logic       d0_vld;
  logic       r0_rdy, o0, b0;
  logic [2:0] c0;
  // DUT 1: MSB first, two stop bits
  logic [7:0] d1_dat;
  logic       d1_vld;
  logic       r1_rdy, o1, b1;
  logic [2:0] c1;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(0), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut0 (
    .clk_115200hz(clk), .reset(rst), .data_in(d0_dat), .valid(d0_vld),
    .ready(r0_rdy), .out(o0), .busy(b0), .fifo_count(c0));

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(2), .MSB_FIRST(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut1 (
    .clk_115200hz(clk), .reset(rst), .data_in(d1_dat), .valid(d1_vld),
    .ready(r1_rdy), .out(o1), .busy(b1), .fifo_count(c1));

`ifdef UART_TX_PARITY_EN
  logic [7:0] d2_dat, d3_dat;
  logic       d2_vld, d3_vld;
  logic       r2_rdy, o2, b2, r3_rdy, o3, b3;
  logic [2:0] c2, c3;

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(0), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut2 (
    .clk_115200hz(clk), .reset(rst), .data_in(d2_dat), .valid(d2_vld),
    .ready(r2_rdy), .out(o2), .busy(b2), .fifo_count(c2));

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(0), .FIFO_DEPTH(4), .PARITY_ODD(1)) dut3 (
    .clk_115200hz(clk), .reset(rst), .data_in(d3_dat), .valid(d3_vld),
    .ready(r3_rdy), .out(o3), .busy(b3), .fifo_count(c3));
`endif

  // Serial receiver on dut0's line, sampling once per bit on the falling edge.
  logic       rx_en = 1'b0;
  int         rx_cnt = 0;
  int         rx_frm_err = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!rx_en) begin
      rx_cnt = 0;
    end else if (rx_cnt == 0) begin
      if (o0 == 1'b0) rx_cnt = 1;
    end else if (rx_cnt <= 8) begin
      rx_byte[rx_cnt-1] = o0;
      rx_cnt++;
    end else begin
      if (o0 == 1'b1) rx_q.push_back(rx_byte);
      else rx_frm_err++;
      rx_cnt = 0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o0 !== 1'b1)     begin errors++; $display("FAIL reset_out0 got %b want 1", o0); end
    checks++; if (r0_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b want 1", r0_rdy); end
    checks++; if (b0 !== 1'b0)     begin errors++; $display("FAIL reset_busy0 got %b want 0", b0); end
    checks++; if (c0 !== 3'd0)     begin errors++; $display("FAIL reset_count0 got %0d want 0", c0); end
    checks++; if (o1 !== 1'b1)     begin errors++; $display("FAIL reset_out1 got %b want 1", o1); end
    checks++; if (b1 !== 1'b0)     begin errors++; $display("FAIL reset_busy1 got %b want 0", b1); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk); d0_vld = 1'b1; d0_dat = 8'h00;
    @(negedge clk);
    @(negedge clk); d0_vld = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL midrst_pre_out got %b want 0", o0); end
    checks++; if (c0 !== 3'd1) begin errors++; $display("FAIL midrst_pre_count got %0d want 1", c0); end
    rst = 1'b1;
    #1;
    checks++; if (o0 !== 1'b1)     begin errors++; $display("FAIL midrst_out got %b want 1", o0); end
    checks++; if (c0 !== 3'd0)     begin errors++; $display("FAIL midrst_count got %0d want 0", c0); end
    checks++; if (r0_rdy !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", r0_rdy); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (o0 !== 1'b1 || b0 !== 1'b0)
        begin errors++; $display("FAIL midrst_idle[%0d] got out=%b busy=%b want out=1 busy=0", k, o0, b0); end
    end
  endtask

  task automatic test_lsb_frame();
    logic [9:0] exp_bits;
    exp_bits = 10'b0_10101100_1;
    @(negedge clk); d0_vld = 1'b1; d0_dat = 8'h35;
    @(negedge clk); d0_vld = 1'b0;
    checks++; if (c0 !== 3'd1) begin errors++; $display("FAIL lsb_count_push got %0d want 1", c0); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL lsb_busy_push got %b want 1", b0); end
    @(negedge clk);
    checks++; if (o0 !== 1'b1) begin errors++; $display("FAIL lsb_latency got %b want 1", o0); end
    checks++; if (c0 !== 3'd0) begin errors++; $display("FAIL lsb_count_pop got %0d want 0", c0); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (o0 !== exp_bits[9-k])
        begin errors++; $display("FAIL lsb_bit[%0d] got %b want %b", k, o0, exp_bits[9-k]); end
      if (k < 9) begin
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL lsb_busy[%0d] got %b want 1", k, b0); end
      end
    end
    @(negedge clk);
    checks++; if (o0 !== 1'b1 || b0 !== 1'b0)
      begin errors++; $display("FAIL lsb_after got out=%b busy=%b want out=1 busy=0", o0, b0); end
  endtask

  task automatic test_msb_two_stop();
    logic [21:0] exp_bits;
    exp_bits = {11'b0_00110101_11, 11'b0_00110101_11};
    @(negedge clk); d1_vld = 1'b1; d1_dat = 8'h35;
    @(negedge clk);
    checks++; if (c1 !== 3'd1) begin errors++; $display("FAIL msb_count_push got %0d want 1", c1); end
    @(negedge clk); d1_vld = 1'b0;
    checks++; if (o1 !== 1'b1) begin errors++; $display("FAIL msb_latency got %b want 1", o1); end
    checks++; if (c1 !== 3'd1) begin errors++; $display("FAIL msb_count_pushpop got %0d want 1", c1); end
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      checks++; if (o1 !== exp_bits[21-k])
        begin errors++; $display("FAIL msb_bit[%0d] got %b want %b", k, o1, exp_bits[21-k]); end
    end
    @(negedge clk);
    checks++; if (o1 !== 1'b1 || b1 !== 1'b0)
      begin errors++; $display("FAIL msb_after got out=%b busy=%b want out=1 busy=0", o1, b1); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp_bits;
    exp_bits = {10'b0_10000000_1, 10'b0_01000000_1, 10'b0_11000000_1};
    @(negedge clk); d0_vld = 1'b1; d0_dat = 8'h01;
    @(negedge clk); d0_dat = 8'h02;
    @(negedge clk); d0_dat = 8'h03;
    @(negedge clk); d0_vld = 1'b0;
    checks++; if (c0 !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", c0); end
    for (int k = 0; k < 30; k++) begin
      checks++; if (o0 !== exp_bits[29-k])
        begin errors++; $display("FAIL b2b_bit[%0d] got %b want %b", k, o0, exp_bits[29-k]); end
      if (k < 29) begin
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %b want 1", k, b0); end
      end
      @(negedge clk);
    end
    checks++; if (o0 !== 1'b1 || b0 !== 1'b0)
      begin errors++; $display("FAIL b2b_after got out=%b busy=%b want out=1 busy=0", o0, b0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [6];
    int         idx;
    logic       acc;
    logic       saw_full;
    words = '{8'hA1, 8'h5B, 8'hC3, 8'h3D, 8'hE4, 8'h7F};
    rx_q.delete();
    rx_frm_err = 0;
    rx_en = 1'b1;
    @(negedge clk);
    idx = 0;
    saw_full = 1'b0;
    d0_vld = 1'b1;
    d0_dat = words[0];
    for (int cyc = 0; cyc < 200 && idx < 6; cyc++) begin
      acc = r0_rdy;
      checks++; if (r0_rdy !== (c0 != 3'd4))
        begin errors++; $display("FAIL bp_ready[%0d] got %b want %b (count %0d)", cyc, r0_rdy, (c0 != 3'd4), c0); end
      if (c0 == 3'd4) saw_full = 1'b1;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 6) d0_dat = words[idx];
        else d0_vld = 1'b0;
      end
    end
    checks++; if (idx !== 6) begin errors++; $display("FAIL bp_accept got %0d words want 6", idx); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_full got %b want 1", saw_full); end
    for (int cyc = 0; cyc < 200 && b0; cyc++) @(negedge clk);
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL bp_drain got busy=%b want 0", b0); end
    repeat (2) @(negedge clk);
    rx_en = 1'b0;
    checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL bp_rx_count got %0d want 6", rx_q.size()); end
    checks++; if (rx_frm_err !== 0) begin errors++; $display("FAIL bp_framing got %0d errors want 0", rx_frm_err); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== words[i])
        begin errors++; $display("FAIL bp_word[%0d] got %h want %h", i, rx_q[i], words[i]); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [21:0] exp_even;
    logic [21:0] exp_odd;
    exp_even = {11'b0_11100000_1_1, 11'b0_11100000_1_1};
    exp_odd  = {11'b0_11100000_0_1, 11'b0_11100000_0_1};
    @(negedge clk); d2_vld = 1'b1; d2_dat = 8'h07; d3_vld = 1'b1; d3_dat = 8'h07;
    @(negedge clk);
    @(negedge clk); d2_vld = 1'b0; d3_vld = 1'b0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      checks++; if (o2 !== exp_even[21-k])
        begin errors++; $display("FAIL par_even_bit[%0d] got %b want %b", k, o2, exp_even[21-k]); end
      checks++; if (o3 !== exp_odd[21-k])
        begin errors++; $display("FAIL par_odd_bit[%0d] got %b want %b", k, o3, exp_odd[21-k]); end
    end
    @(negedge clk);
    checks++; if (o2 !== 1'b1 || b2 !== 1'b0)
      begin errors++; $display("FAIL par_even_after got out=%b busy=%b want out=1 busy=0", o2, b2); end
    checks++; if (o3 !== 1'b1 || b3 !== 1'b0)
      begin errors++; $display("FAIL par_odd_after got out=%b busy=%b want out=1 busy=0", o3, b3); end
  endtask
`endif

  initial begin
    d0_vld = 1'b0; d0_dat = 8'h00;
    d1_vld = 1'b0; d1_dat = 8'h00;
`ifdef UART_TX_PARITY_EN
    d2_vld = 1'b0; d2_dat = 8'h00;
    d3_vld = 1'b0; d3_dat = 8'h00;
`endif
    test_reset();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`else
    test_lsb_frame();
    test_msb_two_stop();
    test_back_to_back();
    test_backpressure();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule
